stream_merger: RTL and testbench

Parametrised two-input streaming merger for sorted record runs, with valid/ready handshakes on every port. Each input carries a sequence of sorted runs, and each run ends with a terminator record (key 0). The block emits one merged sorted run per input run pair and one record per cycle at full throughput. It is the leaf/tree node of the merge tree and replaces the fixed-width, empty/read-style merger nodes.

---
 rtl/bonsai_merge_pkg.sv | 28 ++
 rtl/merge_fifo.sv | 47 ++++
 rtl/stream_merger.sv | 115 +++++++++++
 tb/tb_stream_merger.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bonsai_merge_pkg.sv
// Shared definitions for the merge-tree nodes: terminator key, default widths,
// per-stream run state and the key ordering rule.
package bonsai_merge_pkg;

    localparam logic [63:0] TERM_KEY   = 64'd0;
    localparam int          DEF_KEY_W  = 32;
    localparam int          DEF_DATA_W = 512;

    typedef enum logic {
        RUN_START = 1'b0,
        IN_RUN    = 1'b1
    } run_state_e;

    // True when a must leave before b (a wins ties). Keys are zero-extended
    // to 64 bits. Ascending treats the terminator as +infinity; descending
    // lets it fall out naturally as the minimum.
    function automatic logic key_first(input logic [63:0] a, input logic [63:0] b,
                                       input logic descend);
        if (descend)
            return a >= b;
        if (a == TERM_KEY)
            return b == TERM_KEY;
        if (b == TERM_KEY)
            return 1'b1;
        return a <= b;
    endfunction

endpackage

// File: rtl/merge_fifo.sv
// First-word-fall-through FIFO feeding one side of the merger; head is valid
// whenever empty is low.
module merge_fifo #(
    parameter int DATA_W = 512,
    parameter int DEPTH  = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              enq,
    input  logic [DATA_W-1:0] enq_data,
    input  logic              deq,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = 1;
    localparam logic [AW:0]   CNT_ONE = 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + PTR_ONE;
            if (deq) rd_ptr <= rd_ptr + PTR_ONE;
            if (enq && !deq)
                count <= count + CNT_ONE;
            else if (!enq && deq)
                count <= count - CNT_ONE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (enq) mem[wr_ptr] <= enq_data;
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/stream_merger.sv
// Two-input merger of sorted, terminator-delimited runs with a registered output.
// Define STREAM_MERGER_STATS_EN to add o_rec_count / o_run_count.
module stream_merger
    import bonsai_merge_pkg::*;
#(
    parameter int KEY_W   = DEF_KEY_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEPTH   = 16,
    parameter int DESCEND = 0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_a_data,
    input  logic              i_a_valid,
    output logic              o_a_ready,
    input  logic [DATA_W-1:0] i_b_data,
    input  logic              i_b_valid,
    output logic              o_b_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_order_err
`ifdef STREAM_MERGER_STATS_EN
    ,
    output logic [31:0]       o_rec_count,
    output logic [15:0]       o_run_count
`endif
);
    logic [1:0][DATA_W-1:0] in_data, head;
    logic [1:0][KEY_W-1:0]  key, last_key;
    logic [1:0]             enq, deq, empty, full, term;
    run_state_e             st [2];
    logic                   adv, dec, pick_a, both_term;

    assign in_data   = {i_b_data, i_a_data};
    assign o_a_ready = ~full[0] & ~i_rst;
    assign o_b_ready = ~full[1] & ~i_rst;
    assign enq       = {i_b_valid & o_b_ready, i_a_valid & o_a_ready};

    for (genvar s = 0; s < 2; s++) begin : g_side
        merge_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
            .i_clk    (i_clk),
            .i_rst    (i_rst),
            .enq      (enq[s]),
            .enq_data (in_data[s]),
            .deq      (deq[s]),
            .head     (head[s]),
            .empty    (empty[s]),
            .full     (full[s])
        );
        assign key[s]  = head[s][KEY_W-1:0];
        assign term[s] = (key[s] == KEY_W'(TERM_KEY));
    end

    assign adv       = ~o_valid | i_ready;
    assign dec       = adv & ~empty[0] & ~empty[1];
    assign both_term = term[0] & term[1];
    assign pick_a    = key_first(64'(key[0]), 64'(key[1]), DESCEND != 0);
    // A double terminator also ties, so pick_a already selects A's record.
    assign deq[0]    = dec & (both_term | pick_a);
    assign deq[1]    = dec & (both_term | ~pick_a);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
        end else if (dec) begin
            o_valid <= 1'b1;
            o_data  <= pick_a ? head[0] : head[1];
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

    // Per-stream run tracking; an out-of-order key latches the sticky flag
    // but the record is still forwarded.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int s = 0; s < 2; s++) begin
                st[s]       <= RUN_START;
                last_key[s] <= '0;
            end
            o_order_err <= 1'b0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (deq[s]) begin
                    if (term[s]) begin
                        st[s] <= RUN_START;
                    end else begin
                        if (st[s] == IN_RUN &&
                            !key_first(64'(last_key[s]), 64'(key[s]), DESCEND != 0))
                            o_order_err <= 1'b1;
                        st[s]       <= IN_RUN;
                        last_key[s] <= key[s];
                    end
                end
            end
        end
    end

`ifdef STREAM_MERGER_STATS_EN
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rec_count <= '0;
            o_run_count <= '0;
        end else if (dec) begin
            if (both_term)
                o_run_count <= o_run_count + 16'd1;
            else
                o_rec_count <= o_rec_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_stream_merger.sv
// Bench for stream_merger: directed runs plus random traffic scored against a
// queue-level merge model; an ascending and a descending instance share stimulus.
module tb_stream_merger;
    localparam int KW = 32, DW = 64, DEP = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst = 1'b1;
    logic [DW-1:0] a_data = '0, b_data = '0;
    logic          a_valid = 1'b0, b_valid = 1'b0, rdy = 1'b0;
    logic [DW-1:0] data_u, data_d, m_data;
    logic          valid_u, valid_d, ar_u, ar_d, br_u, br_d, err_u, err_d;
    logic          m_valid, m_ar, m_br, m_erro;
`ifdef STREAM_MERGER_STATS_EN
    logic [31:0]   rc_u, rc_d;
    logic [15:0]   runc_u, runc_d;
`endif

    stream_merger #(.KEY_W(KW), .DATA_W(DW), .DEPTH(DEP), .DESCEND(0)) u_asc (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data), .i_a_valid(a_valid), .o_a_ready(ar_u),
        .i_b_data(b_data), .i_b_valid(b_valid), .o_b_ready(br_u),
        .o_data(data_u), .o_valid(valid_u), .i_ready(rdy), .o_order_err(err_u)
`ifdef STREAM_MERGER_STATS_EN
        , .o_rec_count(rc_u), .o_run_count(runc_u)
`endif
    );

    stream_merger #(.KEY_W(KW), .DATA_W(DW), .DEPTH(DEP), .DESCEND(1)) u_desc (
        .i_clk(clk), .i_rst(rst),
        .i_a_data(a_data), .i_a_valid(a_valid), .o_a_ready(ar_d),
        .i_b_data(b_data), .i_b_valid(b_valid), .o_b_ready(br_d),
        .o_data(data_d), .o_valid(valid_d), .i_ready(rdy), .o_order_err(err_d)
`ifdef STREAM_MERGER_STATS_EN
        , .o_rec_count(rc_d), .o_run_count(runc_d)
`endif
    );

    bit desc = 1'b0;
    assign m_data  = desc ? data_d  : data_u;
    assign m_valid = desc ? valid_d : valid_u;
    assign m_ar    = desc ? ar_d    : ar_u;
    assign m_br    = desc ? br_d    : br_u;
    assign m_erro  = desc ? err_d   : err_u;

    int checks = 0, errors = 0;
    int cyc = 0, vrate = 100, rmode = 0, seq = 0;
    logic [DW-1:0] drv_a[$], drv_b[$], mq_a[$], mq_b[$];
    int  got[$], exp_q[$], ka[$], kb[$];
    bit  acc_a = 0, acc_b = 0, prev_stall = 0, m_err = 0;
    bit  have[2];
    longint last[2];
    int  m_recs = 0, m_runs = 0, nacc_a = 0, first_acc = -1, first_vld = -1;
    logic [DW-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One merge decision on the queued accepted records, straight from the rules.
    task automatic model_step(output bit ok, output logic [DW-1:0] r);
        logic [DW-1:0] ha, hb;
        longint k_a, k_b, e_a, e_b, k;
        bit take_a;
        int src;
        r  = '0;
        ok = (mq_a.size() > 0 && mq_b.size() > 0);
        if (!ok) return;
        ha = mq_a[0];
        hb = mq_b[0];
        k_a = longint'(ha[31:0]);
        k_b = longint'(hb[31:0]);
        if (k_a == 0 && k_b == 0) begin
            r = ha;
            void'(mq_a.pop_front());
            void'(mq_b.pop_front());
            have[0] = 0;
            have[1] = 0;
            m_runs++;
            return;
        end
        e_a = (k_a == 0) ? 64'h1_0000_0000 : k_a;
        e_b = (k_b == 0) ? 64'h1_0000_0000 : k_b;
        take_a = desc ? (k_a >= k_b) : (e_a <= e_b);
        src = take_a ? 0 : 1;
        r   = take_a ? ha : hb;
        k   = take_a ? k_a : k_b;
        if (take_a) void'(mq_a.pop_front()); else void'(mq_b.pop_front());
        if (k == 0) begin
            have[src] = 0;
        end else begin
            if (have[src] && (desc ? (k > last[src]) : (k < last[src]))) m_err = 1;
            have[src] = 1;
            last[src] = k;
            m_recs++;
        end
    endtask

    task automatic monitor();
        bit ok;
        logic [DW-1:0] r;
        acc_a = 0;
        acc_b = 0;
        if (rst) begin
            mq_a.delete();
            mq_b.delete();
            have[0] = 0;
            have[1] = 0;
            m_err = 0;
            m_recs = 0;
            m_runs = 0;
            prev_stall = 0;
            return;
        end
        if (prev_stall) begin
            chk("hold_valid", 64'(m_valid), 1);
            chk("hold_data", m_data, prev_data);
        end
        prev_stall = m_valid && !rdy;
        prev_data  = m_data;
        if (m_valid && first_vld < 0) first_vld = cyc;
        if (m_valid && rdy) begin
            model_step(ok, r);
            chk("heads_present", 64'(ok), 1);
            chk("out_data", m_data, r);
            chk("order_err", 64'(m_erro), 64'(m_err));
            got.push_back(int'(m_data[31:0]));
        end
        acc_a = a_valid && m_ar;
        acc_b = b_valid && m_br;
        if (acc_a) begin
            mq_a.push_back(a_data);
            nacc_a++;
            if (first_acc < 0) first_acc = cyc;
        end
        if (acc_b) mq_b.push_back(b_data);
    endtask

    task automatic step(input bit do_rst = 0);
        @(posedge clk);
        #1;
        cyc++;
        rst = do_rst;
        if (acc_a) void'(drv_a.pop_front());
        if (acc_b) void'(drv_b.pop_front());
        if (do_rst) begin
            drv_a.delete();
            drv_b.delete();
        end
        case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = ($urandom_range(99) < 60);
            default: rdy = ((cyc / 3) % 2) == 0;
        endcase
        if (do_rst) rdy = 1'b0;
        a_valid = drv_a.size() > 0 && $urandom_range(99) < vrate;
        b_valid = drv_b.size() > 0 && $urandom_range(99) < vrate;
        a_data  = drv_a.size() > 0 ? drv_a[0] : '0;
        b_data  = drv_b.size() > 0 ? drv_b[0] : '0;
        @(negedge clk);
        monitor();
    endtask

    task automatic new_test(input bit d, input int vr, input int rm);
        desc  = d;
        vrate = vr;
        rmode = rm;
        step(1);
        step(0);
        chk("rst_valid", 64'(m_valid), 0);
        chk("rst_data", m_data, 0);
        chk("rst_err", 64'(m_erro), 0);
        chk("rst_a_ready", 64'(m_ar), 1);
        chk("rst_b_ready", 64'(m_br), 1);
        got.delete();
        first_acc = -1;
        first_vld = -1;
        nacc_a = 0;
    endtask

    function automatic logic [DW-1:0] mk(input int src, input int key);
        seq++;
        return {8'(src), 24'(seq), 32'(key)};
    endfunction

    task automatic load();
        foreach (ka[i]) drv_a.push_back(mk(0, ka[i]));
        foreach (kb[i]) drv_b.push_back(mk(1, kb[i]));
    endtask

    task automatic drain(input string tag, input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            done = drv_a.size() == 0 && drv_b.size() == 0 && mq_a.size() == 0 &&
                   mq_b.size() == 0 && !m_valid;
            if (done) break;
            step();
        end
        chk({tag, "_drained"}, 64'(done), 1);
`ifdef STREAM_MERGER_STATS_EN
        chk({tag, "_rec_count"}, 64'(desc ? rc_d : rc_u), 64'(m_recs));
        chk({tag, "_run_count"}, 64'(desc ? runc_d : runc_u), 64'(m_runs));
`endif
    endtask

    task automatic compare_got(input string tag);
        chk({tag, "_len"}, 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got.size(); i++)
            chk({tag, "_key"}, 64'(got[i]), 64'(exp_q[i]));
    endtask

    task automatic gen_runs(input int n, input bit d, output int total);
        int tmp[$];
        ka.delete();
        kb.delete();
        total = 0;
        for (int r = 0; r < n; r++) begin
            for (int s = 0; s < 2; s++) begin
                tmp.delete();
                for (int j = 0; j < int'($urandom_range(6)); j++)
                    tmp.push_back(int'($urandom_range(60, 1)));
                if (d) tmp.rsort(); else tmp.sort();
                total += tmp.size();
                foreach (tmp[j]) if (s == 0) ka.push_back(tmp[j]); else kb.push_back(tmp[j]);
                if (s == 0) ka.push_back(0); else kb.push_back(0);
            end
            total++;
        end
    endtask

    initial begin
        int total;
        int tmp[$];

        // Interleaved merge plus minimum latency
        new_test(0, 100, 0);
        ka = {1, 4, 9, 0};
        kb = {2, 3, 10, 0};
        load();
        drain("interleave", 100);
        exp_q = {1, 2, 3, 4, 9, 10, 0};
        compare_got("interleave");
        chk("latency", 64'(first_vld - first_acc), 2);

        // Ties go to A, uneven runs
        new_test(0, 100, 0);
        ka = {5, 5, 0, 0};
        kb = {5, 0, 7, 8, 0};
        load();
        drain("tie", 100);
        exp_q = {5, 5, 5, 0, 7, 8, 0};
        compare_got("tie");
`ifdef STREAM_MERGER_STATS_EN
        chk("tie_runs", 64'(runc_u), 2);
`endif

        // Order violation is sticky, records still forwarded
        new_test(0, 100, 0);
        ka = {6, 2, 0};
        kb = {0};
        load();
        drain("order", 100);
        exp_q = {6, 2, 0};
        compare_got("order");
        for (int i = 0; i < 5; i++) step();
        chk("order_sticky", 64'(m_erro), 1);

        // Descending instance
        new_test(1, 100, 0);
        ka = {9, 3, 0};
        kb = {8, 7, 0};
        load();
        drain("desc", 100);
        exp_q = {9, 8, 7, 3, 0};
        compare_got("desc");

        // FIFO A fills at DEPTH while B is empty
        new_test(0, 100, 0);
        ka.delete();
        for (int i = 1; i <= 20; i++) ka.push_back(i);
        ka.push_back(0);
        kb.delete();
        load();
        for (int i = 0; i < 30; i++) step();
        chk("full_accepts", 64'(nacc_a), DEP);
        chk("full_ready", 64'(m_ar), 0);
        chk("full_no_out", 64'(m_valid), 0);
        ka.delete();
        kb = {0};
        load();
        drain("full", 200);
        chk("full_len", 64'(got.size()), 21);

        // 40-record runs with i_ready toggling every 3 cycles
        new_test(0, 100, 2);
        for (int s = 0; s < 2; s++) begin
            tmp.delete();
            for (int j = 0; j < 40; j++) tmp.push_back(int'($urandom_range(1000, 1)));
            tmp.sort();
            tmp.push_back(0);
            if (s == 0) ka = tmp; else kb = tmp;
        end
        load();
        drain("bp", 600);
        chk("bp_len", 64'(got.size()), 81);

        // Mid-run reset discards everything buffered
        new_test(0, 100, 0);
        ka = {1, 2, 3, 4, 0};
        kb = {5, 6, 0};
        load();
        for (int i = 0; i < 50 && got.size() < 3; i++) step();
        chk("mid_reached3", 64'(got.size() >= 3), 1);
        step(1);
        step(0);
        chk("mid_valid", 64'(m_valid), 0);
        chk("mid_a_ready", 64'(m_ar), 1);
        chk("mid_b_ready", 64'(m_br), 1);
        for (int i = 0; i < 4; i++) step();
        chk("mid_idle", 64'(m_valid), 0);
        got.delete();
        ka = {1, 0};
        kb = {0};
        load();
        drain("mid", 100);
        exp_q = {1, 0};
        compare_got("mid");

        // Random traffic, both orders
        for (int d = 0; d < 2; d++) begin
            new_test(d[0], 70, 1);
            gen_runs(10, d[0], total);
            load();
            drain("rand", 2000);
            chk("rand_len", 64'(got.size()), 64'(total));
            chk("rand_err", 64'(m_erro), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
